mac_tx: RTL and testbench

Ethernet II frame transmitter: the transmit-direction counterpart of mac_rx.
- Takes header fields plus a byte-stream payload and emits one byte per clk to the phy_tx byte interface (tx_data/tx_en/tx_err).
- Emits in order: preamble, SFD, dest MAC, src MAC, type, payload, zero padding, CRC-32 FCS; then enforces the inter-frame gap.
- 802.3x length frames and pause frames are out of scope.

---
 rtl/mac_tx.sv | 272 +++++++++++++++++++++++++++
 tb/tb_mac_tx.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_tx.sv
// Ethernet II frame transmitter: preamble/SFD, header, payload, zero pad, optional FCS, then IFG.
// Build option MAC_TX_FCS_EN: defined -> CRC-32 FCS appended; undefined -> frame ends after pad/data.
module mac_tx #(
  parameter int IFG_BYTES   = 12,
  parameter int MIN_PAYLOAD = 46,
  parameter int MAX_PAYLOAD = 1500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        config_ready,
  input  logic        start,
  input  logic [47:0] dest_mac,
  input  logic [47:0] src_mac,
  input  logic [15:0] ether_type,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  input  logic        s_last,
  output logic        s_ready,
  output logic        busy,
  output logic [7:0]  tx_data,
  output logic        tx_en,
  output logic        tx_err
);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_SFD,
    ST_DEST,
    ST_SRC,
    ST_TYPE,
    ST_DATA,
    ST_PAD,
    ST_FCS,
    ST_IFG
  } state_t;

  localparam logic [10:0] PRE_LAST  = 11'd6;
  localparam logic [10:0] MAC_LAST  = 11'd5;
  localparam logic [10:0] TYPE_LAST = 11'd1;
  localparam logic [10:0] MIN_P     = 11'(MIN_PAYLOAD);
  localparam logic [10:0] MAX_P     = 11'(MAX_PAYLOAD);
  localparam logic [10:0] PAD_LAST  = 11'(MIN_PAYLOAD - 1);
  localparam logic [10:0] IFG_LAST  = 11'(IFG_BYTES - 1);
  localparam state_t END_FRAME = (IFG_BYTES > 0) ? ST_IFG : ST_IDLE;
`ifdef MAC_TX_FCS_EN
  localparam logic [10:0] FCS_LAST  = 11'd3;
  localparam state_t END_PAYLOAD = ST_FCS;
`else
  localparam state_t END_PAYLOAD = END_FRAME;
`endif

  // state_q names the byte that will be driven at the next edge, so the
  // output registers always sit one step behind the state.
  state_t      state_q, state_d;
  logic [10:0] cnt_q, cnt_d;
  logic [10:0] pay_cnt_q, pay_cnt_d;
  logic [47:0] dest_q, dest_d;
  logic [47:0] src_q, src_d;
  logic [15:0] type_q, type_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_en_q, tx_en_d;
  logic        tx_err_q, tx_err_d;
  logic        busy_q, busy_d;
  logic        start_ok;

  function automatic logic [10:0] sat_inc(input logic [10:0] v);
    return (v == 11'h7FF) ? v : v + 11'd1;
  endfunction

  function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [10:0] idx);
    logic [47:0] sh;
    sh = mac << (idx * 8);
    return sh[47:40];
  endfunction

  assign start_ok = start & config_ready;
  assign s_ready  = (state_q == ST_DATA);

`ifdef MAC_TX_FCS_EN
  logic [31:0] crc_q, crc_d;
  logic [7:0]  fcs_byte;

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    return r;
  endfunction

  assign fcs_byte = ~crc_q[{cnt_q[1:0], 3'b000} +: 8];

  always_comb begin
    crc_d = crc_q;
    if (state_q == ST_IDLE && start_ok) begin
      crc_d = 32'hFFFFFFFF;
    end else if (tx_en_d && (state_q inside {ST_DEST, ST_SRC, ST_TYPE, ST_DATA, ST_PAD})) begin
      crc_d = crc_step(crc_q, tx_data_d);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      crc_q <= 32'hFFFFFFFF;
    end else begin
      crc_q <= crc_d;
    end
  end
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pay_cnt_d = pay_cnt_q;
    dest_d    = dest_q;
    src_d     = src_q;
    type_d    = type_q;
    tx_data_d = 8'h00;
    tx_en_d   = 1'b0;
    tx_err_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          dest_d    = dest_mac;
          src_d     = src_mac;
          type_d    = ether_type;
          pay_cnt_d = '0;
          tx_data_d = 8'h55;
          tx_en_d   = 1'b1;
          state_d   = ST_PREAMBLE;
          cnt_d     = 11'd1;
        end
      end
      ST_PREAMBLE: begin
        tx_data_d = 8'h55;
        tx_en_d   = 1'b1;
        if (cnt_q == PRE_LAST) begin
          state_d = ST_SFD;
          cnt_d   = '0;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      ST_SFD: begin
        tx_data_d = 8'hD5;
        tx_en_d   = 1'b1;
        state_d   = ST_DEST;
        cnt_d     = '0;
      end
      ST_DEST: begin
        tx_data_d = mac_byte(dest_q, cnt_q);
        tx_en_d   = 1'b1;
        if (cnt_q == MAC_LAST) begin
          state_d = ST_SRC;
          cnt_d   = '0;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      ST_SRC: begin
        tx_data_d = mac_byte(src_q, cnt_q);
        tx_en_d   = 1'b1;
        if (cnt_q == MAC_LAST) begin
          state_d = ST_TYPE;
          cnt_d   = '0;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      ST_TYPE: begin
        tx_data_d = (cnt_q == '0) ? type_q[15:8] : type_q[7:0];
        tx_en_d   = 1'b1;
        if (cnt_q == TYPE_LAST) begin
          state_d = ST_DATA;
          cnt_d   = '0;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      ST_DATA: begin
        tx_en_d = 1'b1;
        if (!s_valid) begin
          // Underrun: flag a poisoned byte and abandon the frame without FCS.
          tx_err_d = 1'b1;
          state_d  = END_FRAME;
          cnt_d    = '0;
        end else begin
          tx_data_d = s_data;
          pay_cnt_d = pay_cnt_q + 11'd1;
          if (s_last) begin
            cnt_d = (pay_cnt_d < MIN_P) ? pay_cnt_d : 11'd0;
            state_d = (pay_cnt_d < MIN_P) ? ST_PAD : END_PAYLOAD;
          end else if (pay_cnt_q == MAX_P) begin
            tx_err_d = 1'b1;
            state_d  = END_FRAME;
            cnt_d    = '0;
          end
        end
      end
      ST_PAD: begin
        tx_en_d = 1'b1;
        if (cnt_q == PAD_LAST) begin
          state_d = END_PAYLOAD;
          cnt_d   = '0;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
`ifdef MAC_TX_FCS_EN
      ST_FCS: begin
        tx_data_d = fcs_byte;
        tx_en_d   = 1'b1;
        if (cnt_q == FCS_LAST) begin
          state_d = END_FRAME;
          cnt_d   = '0;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
`endif
      ST_IFG: begin
        if (cnt_q == IFG_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = sat_inc(cnt_q);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      pay_cnt_q <= '0;
      dest_q    <= '0;
      src_q     <= '0;
      type_q    <= '0;
      tx_data_q <= 8'h00;
      tx_en_q   <= 1'b0;
      tx_err_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pay_cnt_q <= pay_cnt_d;
      dest_q    <= dest_d;
      src_q     <= src_d;
      type_q    <= type_d;
      tx_data_q <= tx_data_d;
      tx_en_q   <= tx_en_d;
      tx_err_q  <= tx_err_d;
      busy_q    <= busy_d;
    end
  end

  assign tx_data = tx_data_q;
  assign tx_en   = tx_en_q;
  assign tx_err  = tx_err_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_mac_tx.sv
// Self-checking bench for mac_tx: directed frame scenarios with random content,
// checked against a frame-building reference model (FCS bytes only when MAC_TX_FCS_EN).
module tb_mac_tx;

  localparam int IFG  = 12;
  localparam int MAXP = 1500;
`ifdef MAC_TX_FCS_EN
  localparam int MIN_FRAME = 72;
`else
  localparam int MIN_FRAME = 68;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        config_ready;
  logic        start;
  logic [47:0] dest_mac;
  logic [47:0] src_mac;
  logic [15:0] ether_type;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_last;
  logic        s_ready;
  logic        busy;
  logic [7:0]  tx_data;
  logic        tx_en;
  logic        tx_err;

  int tests  = 0;
  int failed = 0;
  logic [7:0] pay[$];

  mac_tx dut (
    .clk          (clk),
    .rst          (rst),
    .config_ready (config_ready),
    .start        (start),
    .dest_mac     (dest_mac),
    .src_mac      (src_mac),
    .ether_type   (ether_type),
    .s_data       (s_data),
    .s_valid      (s_valid),
    .s_last       (s_last),
    .s_ready      (s_ready),
    .busy         (busy),
    .tx_data      (tx_data),
    .tx_en        (tx_en),
    .tx_err       (tx_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Raw reflected CRC register (no final inversion) over a byte list.
  function automatic logic [31:0] crc_raw(input logic [7:0] q[$]);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (q[i]) begin
      c = c ^ {24'h0, q[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  // kind: 0 = normal frame ending with s_last, 1 = underrun at payload index u_at,
  // 2 = oversize (no s_last). Payload comes from the pay queue.
  task automatic run_frame(input string tag, input int kind, input int u_at,
                           input bit drop_cfg, input bit ifg_pulse, output int en_cnt);
    logic [7:0] exp_b[$];
    bit         exp_e[$];
    logic [7:0] body[$];
    logic [7:0] cap[$];
    logic       rec_en[$];
    logic       rec_err[$];
    logic       rec_busy[$];
    logic [7:0] rec_d[$];
    logic [31:0] fcs;
    int n, idx, L, R, mism, bad;
    bit hs, done;

    n = pay.size();
    for (int i = 0; i < 7; i++) begin exp_b.push_back(8'h55); exp_e.push_back(1'b0); end
    exp_b.push_back(8'hD5); exp_e.push_back(1'b0);
    for (int i = 5; i >= 0; i--) body.push_back(dest_mac[8*i +: 8]);
    for (int i = 5; i >= 0; i--) body.push_back(src_mac[8*i +: 8]);
    body.push_back(ether_type[15:8]);
    body.push_back(ether_type[7:0]);
    if (kind == 1) begin
      for (int i = 0; i < u_at; i++) body.push_back(pay[i]);
    end else if (kind == 2) begin
      for (int i = 0; i <= MAXP; i++) body.push_back(pay[i]);
    end else begin
      foreach (pay[i]) body.push_back(pay[i]);
      while (body.size() < 14 + 46) body.push_back(8'h00);
    end
    foreach (body[i]) begin exp_b.push_back(body[i]); exp_e.push_back(1'b0); end
    if (kind == 1) begin exp_b.push_back(8'h00); exp_e.push_back(1'b1); end
    if (kind == 2) exp_e[exp_e.size() - 1] = 1'b1;
`ifdef MAC_TX_FCS_EN
    if (kind == 0) begin
      fcs = ~crc_raw(body);
      for (int i = 0; i < 4; i++) begin exp_b.push_back(fcs[8*i +: 8]); exp_e.push_back(1'b0); end
    end
`endif
    L = exp_b.size();

    idx = 0;
    done = 1'b0;
    @(negedge clk);
    config_ready = 1'b1;
    start = 1'b1;
    s_valid = (idx < n) && !(kind == 1 && idx == u_at);
    s_data  = (idx < n) ? pay[idx] : 8'h00;
    s_last  = (kind == 0) && (idx == n - 1);
    hs = s_ready && s_valid;
    for (int cyc = 0; cyc < L + IFG + 60; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (hs) idx++;
      rec_en.push_back(tx_en);
      rec_err.push_back(tx_err);
      rec_busy.push_back(busy);
      rec_d.push_back(tx_data);
      if (drop_cfg && cyc == 5) config_ready = 1'b0;
      if (ifg_pulse && cyc == L + 2) start = 1'b1;
      s_valid = (idx < n) && !(kind == 1 && idx == u_at);
      s_data  = (idx < n) ? pay[idx] : 8'h00;
      s_last  = (kind == 0) && (idx == n - 1);
      hs = s_ready && s_valid;
      if (busy !== 1'b1) begin done = 1'b1; break; end
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    config_ready = 1'b1;
    R = rec_en.size();

    chk({tag, " done"}, 32'(done), 32'd1);
    en_cnt = 0;
    foreach (rec_en[i]) if (rec_en[i] === 1'b1) en_cnt++;
    chk({tag, " en_count"}, en_cnt, L);
    mism = 0;
    for (int i = 0; i < L; i++) begin
      if (i >= R) mism++;
      else if (rec_en[i] !== 1'b1 || rec_d[i] !== exp_b[i] || rec_err[i] !== exp_e[i]) mism++;
    end
    chk({tag, " bytes"}, mism, 0);
    bad = 0;
    for (int i = L; i < L + IFG; i++) begin
      if (i >= R) bad++;
      else if (rec_en[i] !== 1'b0 || rec_err[i] !== 1'b0) bad++;
      else if (i < L + IFG - 1 && rec_busy[i] !== 1'b1) bad++;
    end
    chk({tag, " ifg"}, bad, 0);
    chk({tag, " busy_fall"}, R, L + IFG);
`ifdef MAC_TX_FCS_EN
    if (kind == 0 && R >= L) begin
      for (int i = 8; i < L; i++) cap.push_back(rec_d[i]);
      chk({tag, " residue"}, crc_raw(cap), 32'hDEBB20E3);
    end
`endif
    bad = 0;
    repeat (IFG + 4) begin
      @(negedge clk);
      if (tx_en !== 1'b0 || busy !== 1'b0) bad++;
    end
    chk({tag, " post_idle"}, bad, 0);
    $display("[TB] frame %s: payload=%0d kind=%0d en_cycles=%0d expected=%0d", tag, n, kind, en_cnt, L);
  endtask

  initial begin
    int bad, en_cnt, n;
    int lens[6];

    rst = 1'b0;
    config_ready = 1'b0;
    start = 1'b0;
    dest_mac = '0;
    src_mac = '0;
    ether_type = '0;
    s_data = '0;
    s_valid = 1'b0;
    s_last = 1'b0;

    #12;
    chk("reset tx_en", 32'(tx_en), 32'd0);
    chk("reset tx_err", 32'(tx_err), 32'd0);
    chk("reset tx_data", 32'(tx_data), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset s_ready", 32'(s_ready), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // start held with PHY unconfigured must not launch a frame
    start = 1'b1;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (tx_en !== 1'b0 || busy !== 1'b0) bad++;
    end
    chk("gate_hold", bad, 0);
    $display("[TB] gating: start held 20 cycles with config_ready=0, violations=%0d", bad);

    dest_mac = 48'hFFFF_FFFF_FFFF;
    src_mac = 48'h0011_2233_4455;
    ether_type = 16'h0800;
    pay.delete();
    for (int i = 1; i <= 10; i++) pay.push_back(8'(i));
    run_frame("min", 0, 0, 1'b0, 1'b1, en_cnt);
    chk("min_len", en_cnt, MIN_FRAME);

    lens[0] = 1;
    lens[1] = 45;
    lens[2] = 46;
    lens[3] = 47;
    lens[4] = int'($urandom_range(2, 200));
    lens[5] = int'($urandom_range(48, 300));
    for (int t = 0; t < 6; t++) begin
      dest_mac = {16'($urandom), $urandom};
      src_mac = {16'($urandom), $urandom};
      ether_type = 16'($urandom);
      pay.delete();
      for (int i = 0; i < lens[t]; i++) pay.push_back(8'($urandom));
      run_frame($sformatf("rand%0d", t), 0, 0, t == 2, t == 3, en_cnt);
    end

    pay.delete();
    for (int i = 0; i < 40; i++) pay.push_back(8'($urandom));
    run_frame("underrun", 1, 19, 1'b0, 1'b0, en_cnt);
    chk("underrun_len", en_cnt, 8 + 14 + 19 + 1);

    pay.delete();
    for (int i = 0; i <= MAXP; i++) pay.push_back(8'($urandom));
    run_frame("oversize", 2, 0, 1'b0, 1'b0, en_cnt);

    pay.delete();
    for (int i = 0; i < MAXP; i++) pay.push_back(8'(i));
    run_frame("large", 0, 0, 1'b0, 1'b0, en_cnt);
    chk("large_len", en_cnt, MIN_FRAME - 46 + MAXP);

    // asynchronous reset while streaming payload
    @(negedge clk);
    config_ready = 1'b1;
    start = 1'b1;
    s_valid = 1'b1;
    s_data = 8'hA5;
    @(negedge clk);
    start = 1'b0;
    repeat (25) @(negedge clk);
    chk("rst_in_data", 32'(s_ready), 32'd1);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("rst_mid tx_en", 32'(tx_en), 32'd0);
    chk("rst_mid tx_err", 32'(tx_err), 32'd0);
    chk("rst_mid busy", 32'(busy), 32'd0);
    chk("rst_mid s_ready", 32'(s_ready), 32'd0);
    $display("[TB] reset mid-frame: tx_en=%0b tx_err=%0b busy=%0b", tx_en, tx_err, busy);
    @(negedge clk);
    s_valid = 1'b0;
    rst = 1'b1;

    n = 5;
    pay.delete();
    for (int i = 0; i < n; i++) pay.push_back(8'($urandom));
    run_frame("after_rst", 0, 0, 1'b0, 1'b0, en_cnt);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
